// File: rtl/apb_arb_pkg.sv
// Shared types and defaults for the APB master arbiter.
// State encoding and default bus widths.
package apb_arb_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

endpackage

// File: rtl/apb_master_arbiter_rr_arbiter.sv
// Round-robin picker: first set request at or above ptr, wrapping.
// Produces a one-hot grant plus the winner index.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               found
);

    // Scan from ptr upward; the first hit wins.
    always_comb begin
        int j;
        j     = 0;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = (int'(ptr) + i) % NUM_REQ;
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB slave among NUM_REQ requesters, round-robin.
// Runs IDLE/SETUP/ACCESS, aborts on wait-state timeout.
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      psel,
    output logic                      penable,
    output logic [ADDR_W-1:0]         paddr,
    output logic                      pwrite,
    output logic [DATA_W-1:0]         pwdata,
    input  logic                      pready,
    input  logic [DATA_W-1:0]         prdata
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    apb_state_t          state;
    apb_state_t          state_nxt;
    logic [IDX_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]    owner;
    logic [IDX_W-1:0]    win;
    logic [NUM_REQ-1:0]  grant;
    logic                found;
    logic [CNT_W-1:0]    cnt;
    logic                cnt_hit;
    logic                accept;
    logic                done;
    logic                abort;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (win),
        .found (found)
    );

    // Last permitted ACCESS cycle is the one where cnt reads TIMEOUT_CYC-1.
    assign cnt_hit = (cnt == CNT_W'(TIMEOUT_CYC - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state, accept pulse and completion strobes; pready beats timeout.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        accept    = 1'b0;
        done      = 1'b0;
        abort     = 1'b0;
        unique case (state)
            IDLE: begin
                if (found && reset) begin
                    req_ready = grant;
                    accept    = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP: state_nxt = ACCESS;
            ACCESS: begin
                if (pready) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else if (cnt_hit) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // APB output registers, wait counter and response registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            paddr     <= '0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
            owner     <= '0;
            rr_ptr    <= '0;
            cnt       <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            if (accept) begin
                paddr  <= req_addr[int'(win)*ADDR_W +: ADDR_W];
                pwdata <= req_wdata[int'(win)*DATA_W +: DATA_W];
                pwrite <= req_write[win];
                owner  <= win;
                rr_ptr <= (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                psel   <= 1'b1;
            end
            if (state == SETUP) begin
                penable <= 1'b1;
                cnt     <= '0;
            end
            if (state == ACCESS) cnt <= cnt + 1'b1;
            if (done || abort) begin
                psel      <= 1'b0;
                penable   <= 1'b0;
                rsp_valid <= NUM_REQ'(1) << owner;
                rsp_err   <= abort;
                rsp_rdata <= (done && !pwrite) ? prdata : '0;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Scoreboard bench for apb_master_arbiter.
// Directed transfers; a monitor pops expected responses.
module tb_apb_master_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req_valid;
    logic [3:0]   req_write;
    logic [39:0]  req_addr;
    logic [127:0] req_wdata;
    logic [3:0]   req_ready;
    logic [3:0]   rsp_valid;
    logic [31:0]  rsp_rdata;
    logic         rsp_err;
    logic         psel;
    logic         penable;
    logic [9:0]   paddr;
    logic         pwrite;
    logic [31:0]  pwdata;
    logic         pready;
    logic [31:0]  prdata;

    typedef struct {
        logic [3:0]  oh;
        logic [31:0] rd;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        sbq[$];
    int          ncmp = 0;
    int          nerr = 0;
    int          cyc = 0;
    bit          mon_en = 0;
    int          slave_waits = 0;
    logic [31:0] slave_rdata = '0;
    logic [9:0]  cur_addr = '0;
    logic        cur_w = 1'b0;
    logic [31:0] cur_data = '0;

    apb_master_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .paddr     (paddr),
        .pwrite    (pwrite),
        .pwdata    (pwdata),
        .pready    (pready),
        .prdata    (prdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pop and compare whenever a response appears.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (mon_en) begin
            if (req_ready != 0) chk("ready_onehot", 64'($onehot(req_ready)), 1);
            if (rsp_valid != 0) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_rsp", 64'(rsp_valid), 0);
                end else begin
                    e = sbq.pop_front();
                    chk("rsp_owner", 64'(rsp_valid), 64'(e.oh));
                    chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rd));
                    chk("rsp_err", 64'(rsp_err), 64'(e.err));
                    chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
                    chk("rsp_bus_idle", 64'({psel, penable}), 0);
                end
            end
        end
    end

    // Slave model: inserts wait states and checks bus stability in ACCESS.
    initial begin
        int wcnt;
        wcnt   = 0;
        pready = 1'b0;
        prdata = '0;
        forever begin
            @(negedge clk);
            if (psel && penable) begin
                chk("acc_paddr", 64'(paddr), 64'(cur_addr));
                chk("acc_pwrite", 64'(pwrite), 64'(cur_w));
                if (cur_w) chk("acc_pwdata", 64'(pwdata), 64'(cur_data));
                if (wcnt < slave_waits) begin
                    pready = 1'b0;
                    prdata = 32'hA5A5_0000 | 32'(wcnt);
                    wcnt++;
                end else begin
                    pready = 1'b1;
                    prdata = slave_rdata;
                end
            end else begin
                pready = 1'b0;
                prdata = 32'h0BAD_0BAD;
                wcnt   = 0;
            end
        end
    end

    task automatic issue(input int i, input bit w, input logic [9:0] a,
                         input logic [31:0] d, input logic [31:0] erd,
                         input bit eerr, input int lat, input bit push,
                         input logic [3:0] also);
        bit   got;
        int   t;
        exp_t e;
        got = 0;
        @(posedge clk);
        #1;
        req_addr[i*10 +: 10]  = a;
        req_wdata[i*32 +: 32] = d;
        req_write[i]          = w;
        req_valid             = req_valid | also | 4'(1 << i);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (req_ready[i]) begin
                got = 1;
                break;
            end
        end
        chk("grant_wait", 64'(got), 1);
        chk("grant_ready", 64'(req_ready), 64'(1 << i));
        t        = cyc;
        cur_addr = a;
        cur_w    = w;
        cur_data = d;
        if (push && got) begin
            e.oh  = 4'(1 << i);
            e.rd  = erd;
            e.err = eerr;
            e.cyc = t + lat;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid = req_valid & ~(also | 4'(1 << i));
        @(negedge clk);
        chk("setup_phase", 64'({psel, penable}), 2'b10);
        @(negedge clk);
        chk("access_phase", 64'({psel, penable}), 2'b11);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (sbq.size() == 0 && !psel) begin
                ok = 1;
                break;
            end
        end
        chk("drain", 64'(ok), 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          prev;
        int          exp_i;
        logic [3:0]  order [5];
        exp_t        e;
        bit          got;
        order     = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
        reset     = 1'b0;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("reset_bus", 64'({psel, penable, pwrite, paddr, pwdata}), 0);
        chk("reset_rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 0);
        chk("reset_ready", 64'(req_ready), 0);
        mon_en = 1;

        // Round robin, all four requesting writes continuously.
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            req_addr[i*10 +: 10]  = 10'(10'h100 + i * 4);
            req_wdata[i*32 +: 32] = 32'hA000_0000 + 32'(i);
        end
        req_write = 4'hF;
        req_valid = 4'hF;
        prev      = 0;
        for (int k = 0; k < 5; k++) begin
            exp_i = int'(order[k]);
            got   = 0;
            for (int n = 0; n < 20; n++) begin
                @(negedge clk);
                if (req_ready != 0) begin
                    got = 1;
                    break;
                end
            end
            chk("rr_wait", 64'(got), 1);
            chk("rr_grant", 64'(req_ready), 64'(1 << exp_i));
            if (k > 0) chk("rr_spacing", 64'(cyc - prev), 3);
            prev     = cyc;
            cur_addr = 10'(10'h100 + exp_i * 4);
            cur_w    = 1'b1;
            cur_data = 32'hA000_0000 + 32'(exp_i);
            e.oh     = 4'(1 << exp_i);
            e.rd     = '0;
            e.err    = 1'b0;
            e.cyc    = cyc + 3;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        req_write = '0;
        wait_idle();

        // Single write, immediate pready.
        slave_waits = 0;
        issue(0, 1, 10'h004, 32'hDEADBEEF, 32'h0, 0, 3, 1, 4'h0);
        wait_idle();

        // Read with three wait states.
        slave_waits = 3;
        slave_rdata = 32'h12345678;
        issue(2, 0, 10'h3FF, 32'h0, 32'h12345678, 0, 6, 1, 4'h0);
        wait_idle();

        // pready on the last permitted ACCESS cycle completes normally.
        slave_waits = 15;
        slave_rdata = 32'hCAFEF00D;
        issue(1, 0, 10'h2AA, 32'h0, 32'hCAFEF00D, 0, 18, 1, 4'h0);
        wait_idle();

        // Timeout: pready never arrives.
        slave_waits = 1000;
        issue(3, 0, 10'h155, 32'h0, 32'h0, 1, 18, 1, 4'h0);
        wait_idle();

        // Reset during ACCESS abandons the transfer.
        issue(1, 1, 10'h0AA, 32'h5555AAAA, 32'h0, 0, 0, 0, 4'h0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_bus", 64'({psel, penable, pwrite, paddr, pwdata}), 0);
        chk("midrst_rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 0);
        slave_waits = 0;
        slave_rdata = 32'h0F0F0F0F;
        req_addr[2*10 +: 10] = 10'h222;
        issue(0, 0, 10'h011, 32'h0, 32'h0F0F0F0F, 0, 3, 1, 4'b0100);
        wait_idle();

        // Withdrawn request from requester 1 during ACCESS of requester 0.
        slave_waits = 4;
        slave_rdata = 32'h77778888;
        issue(0, 0, 10'h020, 32'h0, 32'h77778888, 0, 7, 1, 4'h0);
        @(posedge clk);
        #1;
        req_addr[1*10 +: 10] = 10'h033;
        req_valid[1]         = 1'b1;
        @(negedge clk);
        chk("withdraw_ready", 64'(req_ready), 0);
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        wait_idle();
        repeat (6) @(negedge clk);
        chk("sb_empty", 64'(sbq.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
